fixed_to_fp_seq: RTL

FIXED_TO_FP_SEQ -- requirements
Module: fixed_to_fp_seq

---
 rtl/fixed_to_fp_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fixed_to_fp_seq.sv
// Sequential converter from signed fixed-point to IEEE-754 single precision.
// Normalises one bit per clock, so latency depends on the input's leading zeros.
`timescale 1ns/1ps
module fixed_to_fp_seq #(
    parameter int WORD_LENGTH = 21,
    parameter int FRAC_BITS   = 19
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        DONE = 2'd3
    } state_t;

    // Exponent of a value whose magnitude MSB sits in bit WORD_LENGTH-1
    localparam logic [7:0] EXP_INIT = 8'(127 + WORD_LENGTH - 1 - FRAC_BITS);
    localparam logic [WORD_LENGTH-1:0] MAG_ZERO = {WORD_LENGTH{1'b0}};
    localparam logic [WORD_LENGTH-1:0] MAG_ONE  = {{(WORD_LENGTH-1){1'b0}}, 1'b1};

    state_t                 state_r;
    state_t                 state_s;
    logic [WORD_LENGTH-1:0] mag_r;
    logic [WORD_LENGTH-1:0] abs_s;
    logic [7:0]             exp_r;
    logic                   sign_r;
    logic [31:0]            out_data_r;
    logic                   in_ready_r;
    logic                   out_valid_r;
    logic                   norm_done_s;
    logic [22:0]            mant_s;

    // Magnitude of the incoming sample; the most negative code maps to 2^(WORD_LENGTH-1)
    always_comb begin
        abs_s = in_data;
        if (in_data[WORD_LENGTH-1]) begin
            abs_s = (~in_data) + MAG_ONE;
        end else begin
            abs_s = in_data;
        end
    end

    // Normalisation finished flag and left-aligned mantissa field
    always_comb begin
        norm_done_s = (mag_r == MAG_ZERO) || mag_r[WORD_LENGTH-1];
        mant_s      = 23'(mag_r[WORD_LENGTH-2:0]) << (24 - WORD_LENGTH);
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = NORM;
                end else begin
                    state_s = IDLE;
                end
            end
            NORM: begin
                if (norm_done_s) begin
                    state_s = PACK;
                end else begin
                    state_s = NORM;
                end
            end
            PACK: state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register with handshake flags registered alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Datapath: capture, shift-normalise, pack
    always_ff @(posedge clk) begin
        if (rst) begin
            mag_r      <= MAG_ZERO;
            exp_r      <= 8'd0;
            sign_r     <= 1'b0;
            out_data_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= in_data[WORD_LENGTH-1];
                        mag_r  <= abs_s;
                        exp_r  <= EXP_INIT;
                    end
                end
                NORM: begin
                    if (!norm_done_s) begin
                        mag_r <= mag_r << 1;
                        exp_r <= exp_r - 8'd1;
                    end
                end
                PACK: begin
                    if (mag_r == MAG_ZERO) begin
                        out_data_r <= 32'h0000_0000;
                    end else begin
                        out_data_r <= {sign_r, exp_r, mant_s};
                    end
                end
                DONE: begin
                    out_data_r <= out_data_r;
                end
                default: begin
                    out_data_r <= out_data_r;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule
